// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a program image as a byte stream, assembles
// little-endian 32-bit words, writes them into instruction memory and holds
// the core in reset until the whole image has been loaded.
//
// Stream layout: 2-byte little-endian word count N, then N*4 data bytes.
//
// Optional build macro CHECKSUM_EN: adds a trailing checksum byte (XOR of the
// header and all data bytes). A mismatch rejects the image after the data
// words have already been written.

module imem_boot_loader #(
  parameter int unsigned WD      = 32,
  parameter int unsigned IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               mem_we,
  output logic [IMEM_AW-1:0] mem_addr,
  output logic [WD-1:0]      mem_wdata,
  output logic               core_rst,
  output logic               done,
  output logic               err
);

  localparam int unsigned ImemDepth = 2 ** IMEM_AW;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StData,
`ifdef CHECKSUM_EN
    StCsum,
`endif
    StDone,
    StErr
  } state_e;

  state_e state_q, state_d;

  // Word count latched from the header.
  logic [15:0]        cnt_q;
  // One bit wider than the address so a full memory load does not alias to 0.
  logic [IMEM_AW:0]   widx_q;
  logic [1:0]         lane_q;
  // Lanes 0..2; lane 3 is taken straight from the bus when the word is written.
  logic [WD-9:0]      asm_q;
  logic               mem_we_q;
  logic [IMEM_AW-1:0] mem_addr_q;
  logic [WD-1:0]      mem_wdata_q;
`ifdef CHECKSUM_EN
  logic [7:0]         csum_q;
`endif

  logic        xfer;
  logic [15:0] n_hdr;
  logic        last_word;

  assign xfer      = byte_valid && byte_ready;
  assign n_hdr     = {byte_data, cnt_q[7:0]};
  assign last_word = (32'(widx_q) + 32'd1) == 32'(cnt_q);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: state_d = StHdr0;
      StHdr0: begin
        if (xfer) state_d = StHdr1;
      end
      StHdr1: begin
        if (xfer) begin
          if (n_hdr == 16'd0) begin
            state_d = StDone;
          end else if (32'(n_hdr) > ImemDepth) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer && (lane_q == 2'd3) && last_word) begin
`ifdef CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef CHECKSUM_EN
      StCsum: begin
        if (xfer) state_d = (byte_data == csum_q) ? StDone : StErr;
      end
`endif
      StDone:  state_d = StDone;
      StErr:   state_d = StErr;
      default: state_d = StErr;
    endcase
  end

  // Output decode; done waits for the final write strobe to clear.
  always_comb begin
    byte_ready = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      StHdr0, StHdr1, StData: byte_ready = 1'b1;
`ifdef CHECKSUM_EN
      StCsum:                 byte_ready = 1'b1;
`endif
      StDone:                 done       = !mem_we_q;
      StErr:                  err        = 1'b1;
      default:                byte_ready = 1'b0;
    endcase
    core_rst = !done;
  end

  // Header capture, word assembly and the registered memory write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      widx_q      <= '0;
      lane_q      <= '0;
      asm_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (xfer) begin
        case (state_q)
          StHdr0: cnt_q[7:0]  <= byte_data;
          StHdr1: cnt_q[15:8] <= byte_data;
          StData: begin
            lane_q <= lane_q + 2'd1;
            case (lane_q)
              2'd0: asm_q[7:0]   <= byte_data;
              2'd1: asm_q[15:8]  <= byte_data;
              2'd2: asm_q[23:16] <= byte_data;
              default: begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= widx_q[IMEM_AW-1:0];
                mem_wdata_q <= {byte_data, asm_q};
                widx_q      <= widx_q + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CHECKSUM_EN
  // Running XOR over header and data bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= '0;
    end else if (xfer && (state_q inside {StHdr0, StHdr1, StData})) begin
      csum_q <= csum_q ^ byte_data;
    end
  end
`endif

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // done and err are mutually exclusive.
  assert property (@(posedge clk) disable iff (!rst) !(done && err));
  // No writes once an image has been rejected.
  assert property (@(posedge clk) disable iff (!rst) err |-> !mem_we);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader (IMEM_AW = 8).

module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  xsum;

  logic [7:0] s1 [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                          8'h6F, 8'h00, 8'h00, 8'h00};

  imem_boot_loader #(
    .WD      (32),
    .IMEM_AW (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte after an optional idle gap; returns just after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap, input bit ready_hi);
    byte_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      if (ready_hi) check("ready_in_gap", {31'd0, byte_ready}, 32'd1);
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 20; i++) begin
      if (byte_ready) begin
        tick();
        byte_valid = 1'b0;
        xsum ^= b;
        return;
      end
      tick();
    end
    check("ready_timeout", {31'd0, byte_ready}, 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #20;
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_core_rst", {31'd0, core_rst}, 32'd1);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    xsum = 8'h00;
    check("idle_ready", {31'd0, byte_ready}, 32'd0);
    tick();
  endtask

  // Close a data stream: trailing checksum byte when enabled, else let the last strobe pass.
  task automatic finish_stream();
`ifdef CHECKSUM_EN
    send(xsum, 0, 1'b0);
`else
    tick();
`endif
  endtask

  task automatic check_s1_writes(input string tag);
    check({tag, "_cnt"}, wr_addr.size(), 32'd2);
    check({tag, "_a0"}, {24'd0, wr_addr[0]}, 32'd0);
    check({tag, "_d0"}, wr_data[0], 32'h00A00513);
    check({tag, "_a1"}, {24'd0, wr_addr[1]}, 32'd1);
    check({tag, "_d1"}, wr_data[1], 32'h0000006F);
  endtask

  initial begin
    int bad;

    // Two-word image, back-to-back bytes.
    do_reset();
    check("t1_mem_addr_rst", {24'd0, mem_addr}, 32'd0);
    check("t1_mem_wdata_rst", mem_wdata, 32'd0);
    for (int i = 0; i < 10; i++) send(s1[i], 0, 1'b0);
    check("t1_last_we", {31'd0, mem_we}, 32'd1);
    check("t1_last_addr", {24'd0, mem_addr}, 32'd1);
    check("t1_last_data", mem_wdata, 32'h0000006F);
    check("t1_done_early", {31'd0, done}, 32'd0);
    check("t1_core_rst_early", {31'd0, core_rst}, 32'd1);
    finish_stream();
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_core_rst", {31'd0, core_rst}, 32'd0);
    check("t1_we_off", {31'd0, mem_we}, 32'd0);
    check("t1_ready_off", {31'd0, byte_ready}, 32'd0);
    check("t1_err", {31'd0, err}, 32'd0);
    check_s1_writes("t1");

    // Empty image.
    do_reset();
    send(8'h00, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_core_rst", {31'd0, core_rst}, 32'd0);
    check("t2_ready", {31'd0, byte_ready}, 32'd0);
    tick();
    tick();
    check("t2_done_sticky", {31'd0, done}, 32'd1);
    check("t2_no_writes", wr_addr.size(), 32'd0);

    // Oversized image (257 words).
    do_reset();
    send(8'h01, 0, 1'b0);
    send(8'h01, 0, 1'b0);
    check("t3_err", {31'd0, err}, 32'd1);
    check("t3_core_rst", {31'd0, core_rst}, 32'd1);
    check("t3_ready", {31'd0, byte_ready}, 32'd0);
    check("t3_done", {31'd0, done}, 32'd0);
    tick();
    tick();
    check("t3_err_sticky", {31'd0, err}, 32'd1);
    check("t3_no_writes", wr_addr.size(), 32'd0);

    // Full-memory image (256 words).
    do_reset();
    send(8'h00, 0, 1'b0);
    send(8'h01, 0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 0, 1'b0);
      send(~8'(i), 0, 1'b0);
      send(8'h5A, 0, 1'b0);
      send(8'hC3, 0, 1'b0);
    end
    finish_stream();
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_cnt", wr_addr.size(), 32'd256);
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++) begin
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== {8'hC3, 8'h5A, ~8'(i), 8'(i)}) bad++;
    end
    check("t4_word_errors", bad, 32'd0);
    check("t4_last_addr", {24'd0, wr_addr[255]}, 32'hFF);
    check("t4_last_data", wr_data[255], 32'hC35A00FF);

    // Two-word image with random idle gaps.
    do_reset();
    for (int i = 0; i < 10; i++) send(s1[i], int'($urandom_range(0, 5)), 1'b1);
    finish_stream();
    check("t5_done", {31'd0, done}, 32'd1);
    check_s1_writes("t5");

    // Reset in the middle of word 1, then a fresh image.
    do_reset();
    for (int i = 0; i < 8; i++) send(s1[i], 0, 1'b0);
    check("t6_pre_wdata", mem_wdata, 32'h00A00513);
    #3;
    rst = 1'b0;
    #1;
    check("t6_ready", {31'd0, byte_ready}, 32'd0);
    check("t6_addr", {24'd0, mem_addr}, 32'd0);
    check("t6_wdata", mem_wdata, 32'd0);
    check("t6_core_rst", {31'd0, core_rst}, 32'd1);
    check("t6_done_err", {30'd0, done, err}, 32'd0);
    do_reset();
    send(8'h01, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    send(8'hEF, 0, 1'b0);
    send(8'hBE, 0, 1'b0);
    send(8'hAD, 0, 1'b0);
    send(8'hDE, 0, 1'b0);
    finish_stream();
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_cnt", wr_addr.size(), 32'd1);
    check("t6_a0", {24'd0, wr_addr[0]}, 32'd0);
    check("t6_d0", wr_data[0], 32'hDEADBEEF);

`ifdef CHECKSUM_EN
    // Wrong trailing byte: words are written but the image is rejected.
    do_reset();
    for (int i = 0; i < 10; i++) send(s1[i], 0, 1'b0);
    send(xsum ^ 8'h01, 0, 1'b0);
    check("t7_err", {31'd0, err}, 32'd1);
    check("t7_done", {31'd0, done}, 32'd0);
    check("t7_core_rst", {31'd0, core_rst}, 32'd1);
    check_s1_writes("t7");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
